fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INST, default 32'hD503201F, instruction word presented when the IF/ID slot is a bubble.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_i  input  1  hazard-unit stall: hold PC and IF/ID.
REQ-006 SHALL have port redirect_i  input  1  taken branch resolved in RF stage.
REQ-007 SHALL have port redirect_pc_i  input  64  branch target (PC + sign-extended offset << 2).
REQ-008 SHALL have port imem_addr_o  output  64  instruction-memory address, equal to current PC.
REQ-009 SHALL have port imem_inst_i  input  32  combinational instruction-memory read data for imem_addr_o.
REQ-010 SHALL have port ifid_pc_o  output  64  PC of the instruction held in IF/ID.
REQ-011 SHALL have port ifid_inst_o  output  32  instruction held in IF/ID.
REQ-012 SHALL have port ifid_valid_o  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have port misalign_o  output  1  sticky flag: a redirect target had bits [1:0] nonzero.
REQ-014 SHALL have port fetch_cnt_o  output  32  count of instructions accepted into IF/ID.
REQ-015 SHALL have port squash_cnt_o  output  32  count of wrong-path instructions squashed.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, STALL.
REQ-017 SHALL leave BOOT for RUN on the first edge after reset release; in BOOT, PC holds RESET_PC and IF/ID stays invalid.
REQ-018 SHALL, in RUN with no stall and no redirect, load PC <= PC+4 and IF/ID <= {PC, imem_inst_i, valid=1}; latency IF to IF/ID is 1 cycle.
REQ-019 SHALL, on stall_i=1 without redirect, hold PC and IF/ID unchanged and enter STALL; leave STALL for RUN on the first edge with stall_i=0.
REQ-020 SHALL, on redirect_i=1, load PC <= {redirect_pc_i[63:2], 2'b00} and invalidate IF/ID (squash the wrong-path fetch), from RUN or STALL.
REQ-021 SHALL give redirect priority over stall when both are asserted in the same cycle; the next state is RUN.
REQ-022 SHALL ignore stall_i and redirect_i while in BOOT.
REQ-023 SHALL drive ifid_inst_o = NOP_INST and ifid_pc_o = 64'h0 whenever ifid_valid_o=0.
REQ-024 SHALL compute PC+4 modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 64'h0.
REQ-025 SHALL set misalign_o on a redirect with redirect_pc_i[1:0]!=0; only reset clears it.
REQ-026 SHALL increment fetch_cnt_o per REQ-018 load and squash_cnt_o per redirect that invalidates a valid IF/ID entry; both counters saturate at 32'hFFFF_FFFF.

Reset
REQ-027 SHALL, on reset low, asynchronously set: state=BOOT, PC=RESET_PC, ifid_valid_o=0, ifid_inst_o=NOP_INST, ifid_pc_o=0, misalign_o=0, both counters=0.
REQ-028 SHALL discard any in-flight stall or redirect when reset asserts mid-operation; no state survives reset.

Structure
REQ-029 SHALL place the state enum, NOP_INST default and INST_W=32/ADDR_W=64 constants in shared package fetch_pkg.
REQ-030 SHALL implement both counters with one sub-module, sat_counter (32-bit, enable, saturating), instantiated twice.
REQ-031 SHALL contain no instruction memory; imem is external and combinational.

Verification
REQ-032 SHALL cover this scenario: release reset with RESET_PC=0 -> cycle 1 BOOT with valid=0; then IF/ID PCs are 0, 4, 8 on consecutive cycles and fetch_cnt reaches 3.
REQ-033 SHALL cover this scenario: stall_i high 3 cycles at PC=8 -> PC, ifid_pc_o=4 and fetch_cnt held; resumes at 8 the cycle after stall_i drops.
REQ-034 SHALL cover this scenario: redirect_i with target 0x40 while IF/ID valid -> next cycle PC=0x40, valid=0, squash_cnt +1; the following cycle ifid_pc_o=0x40.
REQ-035 SHALL cover this scenario: stall_i and redirect_i together, target 0x100 -> PC=0x100, state RUN, valid=0.
REQ-036 SHALL cover this scenario: redirect target 0x102 -> PC=0x100 and misalign_o=1, still 1 after 10 further cycles.
REQ-037 SHALL cover these scenarios: reset asserted mid-stall -> all outputs at REQ-027 values immediately without waiting for a clock edge; PC=0xFFFF_FFFF_FFFF_FFFC -> next PC=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP default and fetch FSM state type
package fetch_pkg;
    localparam int INST_W = 32;
    localparam int ADDR_W = 64;
    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'hD503201F;
    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard, redirect, imem and IF/ID signals of the fetch stage
interface fetch_stage_if;
    import fetch_pkg::*;
    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [INST_W-1:0] imem_inst_i;
    logic [ADDR_W-1:0] ifid_pc_o;
    logic [INST_W-1:0] ifid_inst_o;
    logic              ifid_valid_o;
    logic              misalign_o;
    logic [31:0]       fetch_cnt_o;
    logic [31:0]       squash_cnt_o;
    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_inst_i,
        output imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o, misalign_o, fetch_cnt_o, squash_cnt_o
    );
    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_inst_i,
        input  imem_addr_o, ifid_pc_o, ifid_inst_o, ifid_valid_o, misalign_o, fetch_cnt_o, squash_cnt_o
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing with stall/redirect handling and the IF/ID register
module fetch_stage import fetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master f
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, ifid_pc;
    logic [INST_W-1:0] ifid_inst;
    logic              ifid_valid, misalign;
    logic              do_redirect, do_fetch, squash_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= BOOT;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = (state != BOOT && !f.redirect_i && f.stall_i) ? STALL : RUN;
    end

    // leaving STALL costs one hold cycle; only RUN fetches
    always_comb begin
        do_redirect = state != BOOT && f.redirect_i;
        do_fetch    = state == RUN && !f.redirect_i && !f.stall_i;
        squash_en   = do_redirect && ifid_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
            misalign   <= 1'b0;
        end else if (do_redirect) begin
            pc         <= {f.redirect_pc_i[ADDR_W-1:2], 2'b00};
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
            misalign   <= misalign | (|f.redirect_pc_i[1:0]);
        end else if (do_fetch) begin
            pc         <= pc + ADDR_W'(4);
            ifid_valid <= 1'b1;
            ifid_pc    <= pc;
            ifid_inst  <= f.imem_inst_i;
        end
    end

    assign f.imem_addr_o  = pc;
    assign f.ifid_valid_o = ifid_valid;
    assign f.ifid_pc_o    = ifid_valid ? ifid_pc : '0;
    assign f.ifid_inst_o  = ifid_valid ? ifid_inst : NOP_INST;
    assign f.misalign_o   = misalign;

    sat_counter #(.W(32)) u_fetch_cnt (.clk(clk), .reset(reset), .en(do_fetch), .cnt(f.fetch_cnt_o));
    sat_counter #(.W(32)) u_squash_cnt (.clk(clk), .reset(reset), .en(squash_en), .cnt(f.squash_cnt_o));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random stall/redirect traffic against a reference model
module tb_fetch_stage;
    import fetch_pkg::*;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    fetch_stage_if bus();
    fetch_stage dut (.clk(clk), .reset(rst_n), .f(bus.master));

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
    endfunction

    assign bus.imem_inst_i = imem(bus.imem_addr_o);

    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst, m_fc, m_sc;
    logic        m_valid, m_mis, m_boot, m_hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_ipc = 64'h0; m_inst = NOP; m_valid = 1'b0;
        m_mis = 1'b0; m_fc = 0; m_sc = 0; m_boot = 1'b1; m_hold = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pc"}, bus.imem_addr_o, m_pc);
        chk({tag, "_valid"}, 64'(bus.ifid_valid_o), 64'(m_valid));
        chk({tag, "_ipc"}, bus.ifid_pc_o, m_valid ? m_ipc : 64'h0);
        chk({tag, "_inst"}, 64'(bus.ifid_inst_o), 64'(m_valid ? m_inst : NOP));
        chk({tag, "_mis"}, 64'(bus.misalign_o), 64'(m_mis));
        chk({tag, "_fcnt"}, 64'(bus.fetch_cnt_o), 64'(m_fc));
        chk({tag, "_scnt"}, 64'(bus.squash_cnt_o), 64'(m_sc));
    endtask

    // one clock: boot is inert, redirect beats stall, a released stall holds once, else fetch
    task automatic cyc(input logic s, input logic r, input logic [63:0] t, input string tag);
        bus.stall_i = s; bus.redirect_i = r; bus.redirect_pc_i = t;
        if (m_boot) m_boot = 1'b0;
        else if (r) begin
            if (m_valid && m_sc != 32'hFFFF_FFFF) m_sc++;
            m_pc = t & ~64'h3; m_valid = 1'b0; m_ipc = 64'h0; m_inst = NOP;
            if (t % 4 != 0) m_mis = 1'b1;
            m_hold = 1'b0;
        end else if (s) m_hold = 1'b1;
        else if (m_hold) m_hold = 1'b0;
        else begin
            m_ipc = m_pc; m_inst = imem(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
            if (m_fc != 32'hFFFF_FFFF) m_fc++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("boot");
        chk("boot_state", 64'(dut.state), 64'(BOOT));
    endtask

    initial begin
        bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 64'h0;
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(posedge clk);
        release_reset();
        cyc(1'b1, 1'b1, 64'h55, "boot_ign");
        cyc(1'b0, 1'b0, 64'h0, "f0");
        chk("s032_ipc0", bus.ifid_pc_o, 64'h0);
        cyc(1'b0, 1'b0, 64'h0, "f1");
        chk("s032_ipc4", bus.ifid_pc_o, 64'h4);
        repeat (3) cyc(1'b1, 1'b0, 64'h0, "stall");
        chk("s033_pc", bus.imem_addr_o, 64'h8);
        chk("s033_ipc", bus.ifid_pc_o, 64'h4);
        chk("s033_fcnt", 64'(bus.fetch_cnt_o), 64'd2);
        cyc(1'b0, 1'b0, 64'h0, "unstall");
        cyc(1'b0, 1'b0, 64'h0, "f2");
        chk("s032_ipc8", bus.ifid_pc_o, 64'h8);
        chk("s032_fcnt", 64'(bus.fetch_cnt_o), 64'd3);
        cyc(1'b0, 1'b1, 64'h40, "redir40");
        chk("s034_pc", bus.imem_addr_o, 64'h40);
        chk("s034_valid", 64'(bus.ifid_valid_o), 64'd0);
        chk("s034_scnt", 64'(bus.squash_cnt_o), 64'd1);
        cyc(1'b0, 1'b0, 64'h0, "after40");
        chk("s034_ipc", bus.ifid_pc_o, 64'h40);
        cyc(1'b1, 1'b1, 64'h100, "both");
        chk("s035_pc", bus.imem_addr_o, 64'h100);
        chk("s035_state", 64'(dut.state), 64'(RUN));
        chk("s035_valid", 64'(bus.ifid_valid_o), 64'd0);
        cyc(1'b0, 1'b1, 64'h102, "mis");
        chk("s036_pc", bus.imem_addr_o, 64'h100);
        chk("s036_mis", 64'(bus.misalign_o), 64'd1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 64'h0, "mis_hold");
        chk("s036_mis10", 64'(bus.misalign_o), 64'd1);
        cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, "topaddr");
        cyc(1'b0, 1'b0, 64'h0, "wrap");
        chk("wrap_pc", bus.imem_addr_o, 64'h0);
        chk("wrap_ipc", bus.ifid_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (2) cyc(1'b1, 1'b0, 64'h0, "prerst");
        @(negedge clk);
        #2;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 64'h200;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        bus.redirect_i = 1'b0; bus.stall_i = 1'b0;
        release_reset();
        cyc(1'b0, 1'b0, 64'h0, "rboot");
        for (int i = 0; i < 600; i++) begin
            logic s, r;
            logic [63:0] t;
            s = ($urandom_range(3) == 0);
            r = ($urandom_range(9) == 0);
            t = {$urandom, $urandom};
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            cyc(s, r, t, "rnd");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
